// File: rtl/conv_window_feeder_pkg.sv
// Shared constants, FSM state type and tap packing helpers for the conv window feeder.
//   NTAPS/DW/RW : taps per window, pixel/kernel width, conv result width
//   AW/TW       : tap index width, FIRE timer width
//   pack_taps   : unpacked tap array -> flat bus (tap i at bits [DW*i +: DW])
//   get_tap     : flat bus -> single tap
package conv_window_feeder_pkg;

   localparam int unsigned NTAPS   = 21;
   localparam int unsigned DW      = 8;
   localparam int unsigned RW      = 25;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned AW      = 5;
   localparam int unsigned TW      = $clog2(TIMEOUT);
   localparam int unsigned FLATW   = NTAPS * DW;

   typedef enum logic [1:0] {StFill, StFire, StOut} state_e;

   typedef logic [DW-1:0] tap_t;

   function automatic logic [FLATW-1:0] pack_taps(input tap_t taps [NTAPS]);
      logic [FLATW-1:0] flat;
      flat = '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
         flat[i*DW +: DW] = taps[i];
      end
      return flat;
   endfunction

   function automatic tap_t get_tap(input logic [FLATW-1:0] flat, input int unsigned idx);
      return flat[idx*DW +: DW];
   endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Bundle of the feeder's data-path signals: kernel write port, pixel stream, conv
// start/result handshake, result stream and status.
//   master : the feeder (drives pix_ready, conv_*, res_valid/res_data, busy, timeout_err)
//   slave  : the surrounding logic (line buffer, conv array, result consumer)
interface conv_window_feeder_if;
   import conv_window_feeder_pkg::*;

   logic             k_wr_en;
   logic [AW-1:0]    k_addr;
   logic [DW-1:0]    k_data;
   logic             pix_valid;
   logic             pix_ready;
   logic [DW-1:0]    pix_data;
   logic             conv_start;
   logic [FLATW-1:0] conv_kernel;
   logic [FLATW-1:0] conv_x;
   logic [RW-1:0]    conv_result;
   logic             conv_done;
   logic             res_valid;
   logic             res_ready;
   logic [RW-1:0]    res_data;
   logic             busy;
   logic             timeout_err;

   modport master (
      input  k_wr_en, k_addr, k_data, pix_valid, pix_data, conv_result, conv_done, res_ready,
      output pix_ready, conv_start, conv_kernel, conv_x, res_valid, res_data, busy, timeout_err
   );

   modport slave (
      output k_wr_en, k_addr, k_data, pix_valid, pix_data, conv_result, conv_done, res_ready,
      input  pix_ready, conv_start, conv_kernel, conv_x, res_valid, res_data, busy, timeout_err
   );

endinterface

// File: rtl/conv_tap_regfile.sv
// 21 x 8 tap register file with a flat read-out of all taps.
//   clk, reset : clock, synchronous active-high reset (clears every tap)
//   wr_en_i    : write strobe
//   wr_addr_i  : tap index; indices >= NTAPS are dropped
//   wr_data_i  : tap value
//   rd_flat_o  : all taps, tap i at bits [8i+7:8i]
module conv_tap_regfile
   import conv_window_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  tap_t             wr_data_i,
   output logic [FLATW-1:0] rd_flat_o
);

   tap_t mem_q [NTAPS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NTAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i && (wr_addr_i < AW'(NTAPS))) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_flat_o = pack_taps(mem_q);

endmodule

// File: rtl/conv_window_feeder.sv
// Initiator for the 21-tap conv array. Collects a window of 21 pixels, holds conv_start
// high until conv_done (or a timeout), captures the result and offers it on a
// valid/ready stream.
//   clk, reset : clock, synchronous active-high reset
//   bus        : conv_window_feeder_if.master (kernel port, pixel stream, conv handshake,
//                result stream, busy, timeout_err)
module conv_window_feeder
   import conv_window_feeder_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   conv_window_feeder_if.master bus
);

   state_e        state_q;
   logic [AW-1:0] fill_cnt_q;
   logic [TW-1:0] timer_q;
   logic [RW-1:0] shadow_q;
   logic          conv_start_q;
   logic          res_valid_q;
   logic [RW-1:0] res_data_q;
   logic          timeout_err_q;

   logic pix_accept;
   logic k_wr_gated;

   assign bus.pix_ready = (state_q == StFill);
   assign pix_accept    = bus.pix_valid && (state_q == StFill);
   // Kernel must not move under the conv array while it computes; such writes are dropped.
   assign k_wr_gated    = bus.k_wr_en && (state_q != StFire);

   conv_tap_regfile u_kernel (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (k_wr_gated),
      .wr_addr_i (bus.k_addr),
      .wr_data_i (bus.k_data),
      .rd_flat_o (bus.conv_kernel)
   );

   conv_tap_regfile u_window (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (pix_accept),
      .wr_addr_i (fill_cnt_q),
      .wr_data_i (bus.pix_data),
      .rd_flat_o (bus.conv_x)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StFill;
         fill_cnt_q    <= '0;
         timer_q       <= '0;
         shadow_q      <= '0;
         conv_start_q  <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (pix_accept) begin
                  if (fill_cnt_q == AW'(NTAPS - 1)) begin
                     fill_cnt_q   <= '0;
                     timer_q      <= '0;
                     conv_start_q <= 1'b1;
                     state_q      <= StFire;
                  end else begin
                     fill_cnt_q <= fill_cnt_q + 1'b1;
                  end
               end
            end
            StFire: begin
               // conv clears its result on the edge that raises done, so the sum is
               // the value seen one cycle earlier.
               shadow_q <= bus.conv_result;
               if (bus.conv_done) begin
                  res_data_q   <= shadow_q;
                  res_valid_q  <= 1'b1;
                  conv_start_q <= 1'b0;
                  timer_q      <= '0;
                  state_q      <= StOut;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  timeout_err_q <= 1'b1;
                  conv_start_q  <= 1'b0;
                  timer_q       <= '0;
                  state_q       <= StFill;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StOut: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StFill;
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   assign bus.conv_start  = conv_start_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.busy        = !((state_q == StFill) && (fill_cnt_q == '0));

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder with a behavioural conv responder:
// done pulses on the 5th start-high cycle, result is zero on that cycle and shows the
// window sum on the cycles before.
module tb_conv_window_feeder;
   import conv_window_feeder_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_window_feeder_if bus ();

   conv_window_feeder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [RW-1:0] sb [$];
   logic [RW-1:0] sb_exp;

   // Conv responder model
   logic [2:0]    mcnt;
   logic          no_done;
   logic [RW-1:0] msum;

   always @(posedge clk) begin
      if (!bus.conv_start) mcnt <= 3'd0;
      else if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
   end

   always_comb begin
      msum = '0;
      for (int i = 0; i < NTAPS; i++) begin
         msum = msum + RW'(get_tap(bus.conv_kernel, i)) * RW'(get_tap(bus.conv_x, i));
      end
   end

   assign bus.conv_done   = bus.conv_start && (mcnt == 3'd4) && !no_done;
   assign bus.conv_result = (bus.conv_start && mcnt >= 3'd1 && mcnt <= 3'd3) ? msum : '0;

   task automatic check(input string name, input logic [FLATW-1:0] act,
                        input logic [FLATW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result monitor
   always @(negedge clk) begin
      if (!reset && bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL res_unexpected: got %0d expected no result", bus.res_data);
         end else begin
            sb_exp = sb.pop_front();
            check("res_data", bus.res_data, sb_exp);
         end
      end
   end

   task automatic write_kernel(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.k_wr_en = 1'b1;
      bus.k_addr  = a;
      bus.k_data  = d;
      @(posedge clk);
      #1 bus.k_wr_en = 1'b0;
   endtask

   task automatic send_pixel(input logic [DW-1:0] d);
      int n = 0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      @(negedge clk);
      while (!bus.pix_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!bus.pix_ready) check("pix_ready_wait", bus.pix_ready, 1);
      @(posedge clk);
      #1 bus.pix_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic count_start(output int n);
      n = 0;
      @(negedge clk);
      while (bus.conv_start && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_result();
      int n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("res_valid_wait", bus.res_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [FLATW-1:0] exp_flat;
      int nstart;

      reset         = 1'b1;
      no_done       = 1'b0;
      bus.k_wr_en   = 1'b0;
      bus.k_addr    = '0;
      bus.k_data    = '0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pix_ready", bus.pix_ready, 1);
      check("rst_conv_start", bus.conv_start, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_timeout_err", bus.timeout_err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_kernel", bus.conv_kernel, 0);
      check("rst_window", bus.conv_x, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Window 1: kernel all 1, pixels 1..21 -> 231, consumer stalls 10 cycles
      for (int i = 0; i < NTAPS; i++) write_kernel(AW'(i), 8'd1);
      sb.push_back(RW'(231));
      for (int i = 0; i < NTAPS; i++) send_pixel(DW'(i + 1));
      exp_flat = '0;
      for (int i = 0; i < NTAPS; i++) exp_flat[i*DW +: DW] = DW'(i + 1);
      check("w1_conv_x", bus.conv_x, exp_flat);
      check("w1_busy", bus.busy, 1);
      count_start(nstart);
      check("w1_start_cycles", nstart, 5);
      for (int c = 0; c < 10; c++) begin
         check("stall_res_valid", bus.res_valid, 1);
         check("stall_res_data", bus.res_data, 231);
         check("stall_pix_ready", bus.pix_ready, 0);
         check("stall_conv_start", bus.conv_start, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("w1_after_res_valid", bus.res_valid, 0);
      check("w1_after_pix_ready", bus.pix_ready, 1);

      // Windows 2 and 3: kernel tap i = i, pixels 2, pix_valid every other cycle -> 420
      for (int i = 0; i < NTAPS; i++) write_kernel(AW'(i), DW'(i));
      sb.push_back(RW'(420));
      sb.push_back(RW'(420));
      for (int i = 0; i < NTAPS; i++) begin
         send_pixel(8'd2);
         if (i < NTAPS - 1) idle_cycle();
      end
      write_kernel(5'd3, 8'd9);
      check("fire_write_tap3", get_tap(bus.conv_kernel, 3), 3);
      wait_result();
      @(posedge clk);
      #1;
      write_kernel(5'd25, 8'hAA);
      exp_flat = '0;
      for (int i = 0; i < NTAPS; i++) exp_flat[i*DW +: DW] = DW'(i);
      check("oob_write_kernel", bus.conv_kernel, exp_flat);
      for (int i = 0; i < NTAPS; i++) begin
         send_pixel(8'd2);
         if (i < NTAPS - 1) idle_cycle();
      end
      count_start(nstart);
      check("w3_start_cycles", nstart, 5);
      check("w3_start_gap", bus.conv_start, 0);
      @(posedge clk);
      #1;

      // Timeout: responder never raises done
      no_done = 1'b1;
      for (int i = 0; i < NTAPS; i++) send_pixel(8'd1);
      repeat (63) @(posedge clk);
      @(negedge clk);
      check("to_cyc64_err", bus.timeout_err, 0);
      check("to_cyc64_start", bus.conv_start, 1);
      @(negedge clk);
      check("to_err", bus.timeout_err, 1);
      check("to_start", bus.conv_start, 0);
      check("to_res_valid", bus.res_valid, 0);
      check("to_pix_ready", bus.pix_ready, 1);
      check("to_busy", bus.busy, 0);
      no_done = 1'b0;
      sb.push_back(RW'(210));
      @(posedge clk);
      #1;
      for (int i = 0; i < NTAPS; i++) send_pixel(8'd1);
      wait_result();
      @(posedge clk);
      #1;
      check("to_err_sticky", bus.timeout_err, 1);

      // Reset in the middle of FIRE
      for (int i = 0; i < NTAPS; i++) send_pixel(8'd3);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_start", bus.conv_start, 0);
      check("mid_rst_res_valid", bus.res_valid, 0);
      check("mid_rst_timeout_err", bus.timeout_err, 0);
      check("mid_rst_pix_ready", bus.pix_ready, 1);
      check("mid_rst_kernel", bus.conv_kernel, 0);
      check("mid_rst_busy", bus.busy, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Initiator for the 21-tap `conv` responder.
- Holds a 21-entry kernel register file, loaded by a write port.
- Collects 21 streamed 8-bit pixels into a window register, then drives the conv start/hold handshake and captures the convolution result.
- Returns each result on a valid/ready output stream. Sits between the image/line-buffer logic and the conv array.

Parameters:
- NTAPS, 21, taps per window; fixed by the conv interface.
- DW, 8, pixel and kernel width.
- RW, 25, result width.
- TIMEOUT, 64, maximum cycles in FIRE before abort.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- k_wr_en  in  1  kernel write strobe.
- k_addr  in  5  kernel tap index 0..20.
- k_data  in  8  kernel value.
- pix_valid  in  1  pixel stream valid.
- pix_ready  out  1  pixel stream ready.
- pix_data  in  8  pixel value; the first accepted pixel is tap 0.
- conv_start  out  1  to conv start; held high for the whole operation.
- conv_kernel  out  168  Kernel_0..20 flattened; tap i is bits [8i+7:8i].
- conv_x  out  168  X_0..20 flattened, same packing.
- conv_result  in  25  conv result.
- conv_done  in  1  conv done.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready.
- res_data  out  25  captured result.
- busy  out  1  high in any state other than FILL with fill count 0.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset values:
  - state FILL, fill_cnt 0, timer 0.
  - pix_ready 1, conv_start 0, res_valid 0, res_data 0, timeout_err 0, busy 0.
  - kernel and window registers all 0.
- Kernel write: tap k_addr <= k_data when k_wr_en=1 and k_addr<21.
  - Writes with k_addr>=21 are ignored.
  - Writes are ignored while state=FIRE, so conv inputs stay stable; the write is lost, not deferred.
- FILL:
  - pix_ready=1.
  - On pix_valid&pix_ready: x[fill_cnt] <= pix_data, fill_cnt++.
  - On acceptance of the 21st pixel (fill_cnt==20): fill_cnt <= 0, go to FIRE next cycle.
- FIRE:
  - pix_ready=0, conv_start=1 (registered), timer++ each cycle.
  - shadow <= conv_result every cycle.
  - conv zeroes its result in the same edge that raises done. The valid sum is therefore the value present on the cycle before done.
  - On conv_done=1: res_data <= shadow (not conv_result), res_valid <= 1, conv_start <= 0, timer <= 0, go to OUT.
  - If timer reaches TIMEOUT-1 without done: timeout_err <= 1 (sticky), conv_start <= 0, timer <= 0, window discarded, go to FILL. No result is emitted.
  - conv_done and timeout in the same cycle: done wins.
- OUT:
  - conv_start=0, so conv clears result and done.
  - res_valid held with res_data stable until res_valid&res_ready.
  - On handshake: res_valid <= 0, go to FILL.
  - pix_ready=0 in OUT. This guarantees at least one start-low cycle between operations.
- conv_done seen outside FIRE is ignored.
- Reset mid-operation: every state and output returns to its reset value on the next edge. The kernel file is cleared and must be reloaded.
- Throughput: 21 pixel cycles + FIRE latency + at least 1 OUT cycle per result.

Decomposition:
- Shared package:
  - NTAPS, DW, RW constants.
  - State enum: FILL, FIRE, OUT.
  - Tap pack/unpack helper function.
- One natural sub-module: conv_tap_regfile, a 21x8 register file with a flat 168-bit read-out. Instantiated twice: kernel (addressed write) and window (sequential write).

Test Plan:
- Bench conv model: done pulses 5 cycles after start rises; on that cycle result=0 and the previous cycle showed the window sum.
- Kernel all 1, pixels 1..21 → conv_x taps equal 1..21, conv_start high 5 cycles, res_data=231, res_valid held until res_ready.
- res_ready held low 10 cycles after valid → res_data stable at 231, pix_ready=0 throughout, conv_start=0.
- pix_valid toggled every other cycle over 2 windows (kernel tap i=i, pixels all 2) → two results of 420, start low at least 1 cycle between them.
- k_wr_en (addr 3, data 9) during FIRE → conv_kernel tap 3 unchanged. k_addr=25 write in FILL → no tap changes.
- Model never asserts done → timeout_err=1 at FIRE cycle 64, no res_valid, state FILL, next window accepted normally.
- Reset asserted mid-FIRE → next cycle conv_start=0, res_valid=0, timeout_err=0, pix_ready=1, kernel taps 0.
